// File: rtl/handshake_constant_seq.sv
// Elastic constant/sequence source: each accepted control token emits COUNT tokens
// VALUE, VALUE+STRIDE, ... through a one-entry output slot. Optional outs_last via HANDSHAKE_CONSTANT_SEQ_LAST_EN.
module handshake_constant_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int VALUE      = 0,
  parameter int STRIDE     = 1,
  parameter int COUNT      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  ,
  output logic                  outs_last
`endif
);

  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1;

  localparam logic [DATA_WIDTH-1:0] VALUE_W  = DATA_WIDTH'(VALUE);
  localparam logic [DATA_WIDTH-1:0] STRIDE_W = DATA_WIDTH'(STRIDE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  if (COUNT < 1 || COUNT > 65535) begin : g_count_check
    $error("handshake_constant_seq: COUNT must be in 1..65535");
  end

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic [IDX_W-1:0]      idx;

  logic pop;
  logic accept;
  logic last_step;

  assign pop        = valid_r && outs_ready;
  // Only the slot-drain term reaches ctrl_ready from downstream; the burst itself is registered.
  assign ctrl_ready = (state == S_IDLE) && (!valid_r || outs_ready) && !rst;
  assign accept     = ctrl_valid && ctrl_ready;
  // True when the pop in progress moves the final token of the burst into the slot.
  assign last_step  = (int'(idx) + 1 == COUNT - 1);

  assign outs       = data_r;
  assign outs_valid = valid_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      data_r  <= '0;
      valid_r <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            data_r  <= VALUE_W;
            valid_r <= 1'b1;
            idx     <= '0;
            state   <= (COUNT > 1) ? S_EMIT : S_IDLE;
          end else if (pop) begin
            valid_r <= 1'b0;
          end
        end
        S_EMIT: begin
          if (pop) begin
            data_r <= data_r + STRIDE_W;
            idx    <= idx + 1'b1;
            if (last_step) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  logic last_r;

  // Tracks data_r: loaded on accept and on each in-burst advance, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept)   last_r <= (COUNT == 1);
      else if (pop) last_r <= 1'b0;
    end else if (pop) begin
      last_r <= last_step;
    end
  end

  assign outs_last = last_r;
`endif

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Self-checking bench: five differently parameterised instances share one stimulus stream and
// are compared each cycle against a token-count reference model.
module tb_handshake_constant_seq;

  localparam int N  = 5;
  localparam int DW = 13;

  localparam int V0 = 'h0D21, S0 = 1,  C0 = 1;
  localparam int V1 = 10,     S1 = 3,  C1 = 4;
  localparam int V2 = 'h1FFE, S2 = 1,  C2 = 4;
  localparam int V3 = 1,      S3 = -1, C3 = 4;
  localparam int V4 = 7,      S4 = 2,  C4 = 3;

  int m_val [N] = '{V0, V1, V2, V3, V4};
  int m_str [N] = '{S0, S1, S2, S3, S4};
  int m_cnt [N] = '{C0, C1, C2, C3, C4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ctrl_valid;
  logic          outs_ready;
  logic          rdy [N];
  logic          vld [N];
  logic [DW-1:0] dat [N];
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  logic          lst [N];
`endif

  // Model state: tokens of the current burst not yet transferred (slot included).
  int pending [N];
  bit zeroed  [N];

  int n_pass  = 0;
  int n_total = 0;

  handshake_constant_seq #(.DATA_WIDTH(DW), .VALUE(V0), .STRIDE(S0), .COUNT(C0)) u0 (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(rdy[0]),
    .outs(dat[0]), .outs_valid(vld[0]), .outs_ready(outs_ready)
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    , .outs_last(lst[0])
`endif
  );
  handshake_constant_seq #(.DATA_WIDTH(DW), .VALUE(V1), .STRIDE(S1), .COUNT(C1)) u1 (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(rdy[1]),
    .outs(dat[1]), .outs_valid(vld[1]), .outs_ready(outs_ready)
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    , .outs_last(lst[1])
`endif
  );
  handshake_constant_seq #(.DATA_WIDTH(DW), .VALUE(V2), .STRIDE(S2), .COUNT(C2)) u2 (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(rdy[2]),
    .outs(dat[2]), .outs_valid(vld[2]), .outs_ready(outs_ready)
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    , .outs_last(lst[2])
`endif
  );
  handshake_constant_seq #(.DATA_WIDTH(DW), .VALUE(V3), .STRIDE(S3), .COUNT(C3)) u3 (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(rdy[3]),
    .outs(dat[3]), .outs_valid(vld[3]), .outs_ready(outs_ready)
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    , .outs_last(lst[3])
`endif
  );
  handshake_constant_seq #(.DATA_WIDTH(DW), .VALUE(V4), .STRIDE(S4), .COUNT(C4)) u4 (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(rdy[4]),
    .outs(dat[4]), .outs_valid(vld[4]), .outs_ready(outs_ready)
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    , .outs_last(lst[4])
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // k-th token of a burst: VALUE + k*STRIDE modulo 2^DW.
  function automatic logic [DW-1:0] exp_token(input int i, input int k);
    longint v;
    v = longint'(m_val[i]) + longint'(m_str[i]) * longint'(k);
    return v[DW-1:0];
  endfunction

  // One clock cycle: drive inputs, check every instance before the edge, advance the model.
  task automatic cycle(input logic cv, input logic ordy, input logic r);
    int  nxt [N];
    bit  nz  [N];
    logic exp_rdy;
    ctrl_valid = cv;
    outs_ready = ordy;
    rst        = r;
    #2;
    for (int i = 0; i < N; i++) begin
      exp_rdy = !r && (pending[i] == 0 || (pending[i] == 1 && ordy));
      check($sformatf("u%0d.ctrl_ready", i), 32'(rdy[i]), 32'(exp_rdy));
      check($sformatf("u%0d.outs_valid", i), 32'(vld[i]), 32'(pending[i] > 0));
      if (pending[i] > 0) begin
        check($sformatf("u%0d.outs", i), 32'(dat[i]),
              32'(exp_token(i, m_cnt[i] - pending[i])));
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
        check($sformatf("u%0d.outs_last", i), 32'(lst[i]), 32'(pending[i] == 1));
`endif
      end else if (zeroed[i]) begin
        check($sformatf("u%0d.outs_after_rst", i), 32'(dat[i]), 32'd0);
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
        check($sformatf("u%0d.outs_last_after_rst", i), 32'(lst[i]), 32'd0);
`endif
      end
      nz[i] = zeroed[i];
      if (r) begin
        nxt[i] = 0;
        nz[i]  = 1'b1;
      end else begin
        nxt[i] = pending[i] - ((pending[i] > 0 && ordy) ? 1 : 0);
        if (cv && exp_rdy) begin
          nxt[i] = m_cnt[i];
          nz[i]  = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      pending[i] = nxt[i];
      zeroed[i]  = nz[i];
    end
  endtask

  initial begin
    rst        = 1'b1;
    ctrl_valid = 1'b0;
    outs_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      pending[i] = 0;
      zeroed[i]  = 1'b1;
    end

    // Reset held: slot empty, outs zero, ctrl_ready forced low.
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);

    // Single control pulse, free-flowing downstream.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);

    // Control held for 5 cycles: back-to-back tokens / bursts.
    repeat (5) cycle(1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);

    // Long control run: consecutive bursts with no bubble at the boundary.
    repeat (12) cycle(1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);

    // Random control with roughly 30% downstream acceptance.
    repeat (300) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3), 1'b0);
    repeat (12) cycle(1'b0, 1'b1, 1'b0);

    // Reset after two of four tokens have transferred, then a fresh burst.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);

    // Stall mid-burst for several cycles, then drain.
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/handshake_constant_seq.md
Name: handshake_constant_seq

Overview:
Parametrised successor of the per-kernel handshake constant: each accepted control token launches a burst of COUNT data tokens VALUE, VALUE+STRIDE, VALUE+2*STRIDE, ... on an elastic output channel. Output is registered in a one-entry slot, so ctrl_ready has no combinational dependence on downstream beyond the slot-drain term. Used in generated dataflow circuits for constants, loop-index seeds and short index streams. With COUNT=1 it is a registered drop-in for a plain constant.

Parameters:
DATA_WIDTH, 32, width of outs.
VALUE, 0, first emitted value; truncated to DATA_WIDTH.
STRIDE, 1, increment between successive tokens in a burst; two's complement, truncated to DATA_WIDTH.
COUNT, 1, tokens emitted per control token; legal range 1..65535; elaboration error outside this range.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
ctrl_valid  input  1  control token present
ctrl_ready  output  1  control token accepted when ctrl_valid && ctrl_ready
outs  output  DATA_WIDTH  data token
outs_valid  output  1  data token present
outs_ready  input  1  downstream accepts; transfer when outs_valid && outs_ready

Behaviour:
- Synchronous reset, active-high, single clock clk. In reset cycle and after it: outs_valid=0, outs=0, state=IDLE, idx=0. ctrl_ready forced 0 while rst=1.
- State: FSM {IDLE, EMIT}; output slot (data_r, valid_r); burst index idx, width clog2(COUNT).
- pop = valid_r && outs_ready.
- ctrl_ready = (state==IDLE) && (!valid_r || outs_ready) && !rst.
- IDLE, ctrl accepted: data_r<=VALUE, valid_r<=1, idx<=0. Next state EMIT if COUNT>1, else IDLE.
- IDLE, no accept, pop: valid_r<=0.
- EMIT, pop: data_r<=data_r+STRIDE, idx<=idx+1, valid_r stays 1. If idx+1==COUNT-1, next state IDLE (last token now in slot), else stay EMIT.
- EMIT, no pop: hold everything.
- Latency: ctrl accepted at edge N -> outs_valid=1, outs=VALUE after edge N. Sustained throughput is 1 token/cycle, including back-to-back bursts: last token pop and next ctrl accept in the same cycle.
- Stability: while outs_valid && !outs_ready, outs and outs_valid hold.
- Arithmetic: addition modulo 2^DATA_WIDTH; wrap-around is silent, no saturation.
- ctrl_valid is ignored in EMIT; control tokens queue upstream.
- Reset mid-burst: remaining tokens are dropped, slot emptied, return to IDLE.

Optional Feature:
Macro HANDSHAKE_CONSTANT_SEQ_LAST_EN.
- Defined: extra port outs_last (output, 1), asserted with the token whose idx==COUNT-1. For COUNT=1 it is asserted on every token. Registered with data_r and held under backpressure. Reset value 0.
- Undefined: port absent; no extra logic.

Test Plan:
1. DATA_WIDTH=13, VALUE=13'h0D21, COUNT=1. One ctrl pulse, outs_ready=1 -> one token 0x0D21 the cycle after accept, then outs_valid=0. ctrl_valid held high 5 cycles -> 5 consecutive tokens 0x0D21, ctrl_ready high every cycle.
2. VALUE=10, STRIDE=3, COUNT=4, outs_ready=1 -> tokens 10,13,16,19 on 4 consecutive cycles. ctrl_ready=0 during the burst, 1 again in the cycle the 19 is popped. Back-to-back ctrl -> next burst begins immediately with 10 and no bubble.
3. DATA_WIDTH=13, VALUE=13'h1FFE, STRIDE=1, COUNT=4 -> 0x1FFE, 0x1FFF, 0x0000, 0x0001. STRIDE=-1 from VALUE=1 -> 1, 0, 0x1FFF, 0x1FFE.
4. COUNT=4, outs_ready random 30% -> exactly 4 transfers per ctrl, in order. outs stable while stalled. No ctrl accepted mid-burst.
5. rst asserted after 2 of 4 tokens -> outs_valid=0 and outs=0 the next cycle. After reset, a new ctrl yields the full sequence from VALUE.
6. LAST_EN defined, COUNT=3 -> outs_last pattern 0,0,1 per burst, held under stall. COUNT=1 -> outs_last=1 on every token.
